// File: rtl/multiword_add_pkg.sv
// multiword_add_pkg: shared word width and FSM encoding for the sequential multi-word adder
package multiword_add_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/kogge_stone_32bits.sv
// kogge_stone_32bits: combinational parallel-prefix adder with carry in/out
module kogge_stone_32bits #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH-1:0] g, p, gn, pn;
  logic [WIDTH:0] c;
  // log2(WIDTH) prefix levels, each combining spans twice as wide as the last
  always_comb begin
    g = a & b;
    p = a ^ b;
    gn = g;
    pn = p;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < WIDTH; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    c = {g | (p & {WIDTH{cin}}), cin};
  end
  assign s = a ^ b ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];
endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: multi-precision add/subtract streaming one 32-bit slice per cycle through a shared adder
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_W*WORDS-1:0] A,
  input  logic [WORD_W*WORDS-1:0] B,
  input  logic                   Sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_W*WORDS-1:0] S,
  output logic                   Cout,
  output logic                   Ovf
);
  localparam int N = WORD_W * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  state_t state, state_nx;
  logic [N-1:0] opa, opb;
  logic carry, co, last;
  logic [KW-1:0] k;
  logic [WORD_W-1:0] sum;
  assign last = k == KW'(WORDS - 1);
  kogge_stone_32bits #(.WIDTH(WORD_W)) u_add (
    .a   (opa[WORD_W*k +: WORD_W]),
    .b   (opb[WORD_W*k +: WORD_W]),
    .cin (carry),
    .s   (sum),
    .cout(co)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE && in_valid) ? RUN :
               (state == RUN && last) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  // Subtraction is A + ~B + 1: the +1 enters as the initial carry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opa <= '0;
      opb <= '0;
      carry <= 1'b0;
      k <= '0;
      S <= '0;
      Cout <= 1'b0;
      Ovf <= 1'b0;
    end else begin
      if (in_ready && in_valid) begin
        opa <= A;
        opb <= Sub ? ~B : B;
        carry <= Sub;
        k <= '0;
      end
      if (state == RUN) begin
        S[WORD_W*k +: WORD_W] <= sum;
        carry <= co;
        if (last) begin
          Cout <= co;
          Ovf <= (opa[N-1] == opb[N-1]) && (sum[WORD_W-1] != opa[N-1]);
        end else k <= k + 1'b1;
      end
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: randomized and directed check of multiword_add_seq against a wide-arithmetic model
module tb_multiword_add_seq;
  localparam int WORDS = 4;
  localparam int N = 32 * WORDS;
  logic clk, rst_n, in_valid, in_ready, Sub, out_valid, out_ready, Cout, Ovf;
  logic [N-1:0] A, B, S;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0;
  bit busy = 0, was_busy, exp_v;
  logic [N-1:0] exp_s, got_s;
  logic exp_c, exp_o, got_c, got_o;
  logic signed [N:0] se;

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] r;
    for (int w = 0; w < WORDS; w++)
      case ($urandom % 4)
        0: r[32*w +: 32] = '0;
        1: r[32*w +: 32] = '1;
        default: r[32*w +: 32] = $urandom;
      endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0;
      chk("rst in_ready", in_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst S", S, 0);
      chk("rst Cout", Cout, 0);
      chk("rst Ovf", Ovf, 0);
    end else begin
      was_busy = busy;
      exp_v = busy && (cyc >= acc_cyc + WORDS);
      chk("in_ready", in_ready, !busy);
      chk("out_valid", out_valid, exp_v);
      if (exp_v) begin
        chk("S", S, exp_s);
        chk("Cout", Cout, exp_c);
        chk("Ovf", Ovf, exp_o);
        if (out_ready) busy = 0;
      end
      if (!was_busy && in_valid) begin
        if (Sub) begin
          exp_s = A - B;
          exp_c = A >= B;
          se = $signed({A[N-1], A}) - $signed({B[N-1], B});
        end else begin
          {exp_c, exp_s} = {1'b0, A} + {1'b0, B};
          se = $signed({A[N-1], A}) + $signed({B[N-1], B});
        end
        exp_o = se[N] != se[N-1];
        busy = 1;
        acc_cyc = cyc + 1;
      end
    end
  end

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub, input int hold);
    in_valid = 1;
    A = a;
    B = b;
    Sub = sub;
    for (int i = 0; i < 20 && !in_ready; i++) begin @(posedge clk); #1; end
    chk("accept wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    A = rand_op();
    B = rand_op();
    Sub = 1'($urandom);
    for (int i = 0; i < 20 && !out_valid; i++) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    out_ready = 0;
    chk("out_valid wait", out_valid, 1);
    got_s = S;
    got_c = Cout;
    got_o = Ovf;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    clk = 0; rst_n = 1; in_valid = 0; A = '0; B = '0; Sub = 0; out_ready = 0;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    do_op({N{1'b1}}, 1, 0, 0);
    chk("ripple S", got_s, 0);
    chk("ripple Cout", got_c, 1);
    chk("ripple Ovf", got_o, 0);
    do_op(0, 1, 1, 0);
    chk("borrow S", got_s, {N{1'b1}});
    chk("borrow Cout", got_c, 0);
    chk("borrow Ovf", got_o, 0);
    do_op({1'b0, {(N-1){1'b1}}}, 1, 0, 5);
    chk("ovf S", got_s, {1'b1, {(N-1){1'b0}}});
    chk("ovf Cout", got_c, 0);
    chk("ovf Ovf", got_o, 1);
    do_op(12, 5, 1, 1);
    chk("sub S", got_s, 7);
    chk("sub Cout", got_c, 1);
    in_valid = 1; A = rand_op() | 1; B = rand_op(); Sub = 0;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    chk("midrun out_valid", out_valid, 0);
    chk("midrun S", S, 0);
    chk("midrun in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;
    do_op(5, 7, 0, 0);
    chk("fresh S", got_s, 12);
    for (int n = 0; n < 1000; n++) do_op(rand_op(), rand_op(), 1'($urandom), $urandom_range(0, 3));
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequential multi-precision adder/subtractor that streams WORDS × 32-bit operand slices through a single instance of the team's 32-bit Kogge-Stone adder, one slice per cycle, least significant first. The 32-bit carry out is registered and fed back as the carry in of the next slice. It sits directly upstream of the adder, driving its A/B/Cin and consuming its S/Cout. It presents valid/ready handshakes on both sides, so 64/128/256-bit datapaths can use it without a wider combinational adder.

## Interface
- WORDS, 4, number of 32-bit slices per operand (≥2); operand width N = 32·WORDS
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept; high only in IDLE
- A  in  N  operand A, sampled on accept
- B  in  N  operand B, sampled on accept
- Sub  in  1  1 = A − B, 0 = A + B; sampled on accept
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- S  out  N  sum/difference, registered
- Cout  out  1  carry out of bit N−1 (for Sub: 1 = no borrow)
- Ovf  out  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready:
  - latch A into opA.
  - latch B into opB, as B when Sub=0 and ~B when Sub=1.
  - carry ← Sub; k ← 0; go to RUN.
- RUN: adder inputs are opA[32k+:32], opB[32k+:32], Cin=carry.
  - Each cycle: S[32k+:32] ← adder S; carry ← adder Cout.
  - If k=WORDS−1: go to DONE, Cout ← adder Cout, Ovf ← (opA[N−1]==opB[N−1]) && (adder S[31]!=opA[N−1]). Otherwise k ← k+1.
  - in_ready=0.
- DONE: out_valid=1, with S/Cout/Ovf stable. On out_ready, go to IDLE.
  - S/Cout/Ovf keep their values in IDLE until the next operation overwrites them.
- No Cin port on this block. The carry chain starts from Sub only.
- Inputs A/B/Sub are don't-care outside the accept cycle.
- k counter width: $clog2(WORDS), minimum 1 bit.
- Words of S not yet written in RUN hold their old values. S is only meaningful while out_valid=1.

## Timing
- Reset values while rst_n=0:
  - state=IDLE, so in_ready=1 after reset.
  - out_valid=0, S=0, Cout=0, Ovf=0, carry=0, k=0.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted immediately and asynchronously, and no result is presented.
- Latency: accept at edge T0, slices computed at edges T1..T_WORDS, out_valid high after edge T_WORDS.
  - WORDS cycles from accept to out_valid.
- Throughput: if out_ready is already high in DONE, one op per WORDS+2 cycles (DONE→IDLE→accept).
- Backpressure: out_ready low holds DONE indefinitely with all outputs frozen.
- in_ready is a combinational decode of state. It does not depend on in_valid or out_ready.
- The adder is combinational. Critical path: opA/opB word mux → adder → S/carry registers, one adder delay per cycle.

## Structure
- Package multiword_add_pkg holds:
  - WORD_W=32
  - state_t enum {IDLE, RUN, DONE}
- One sub-module: kogge_stone_32bits, instantiated once, WIDTH=32.
- Word select is an indexed part-select on opA/opB by k. No per-word adder instances.

## Test plan
- Carry ripple across all words: WORDS=4, A=2^128−1, B=1, Sub=0.
  - Expected after 4 cycles: S=0, Cout=1, Ovf=0.
- Borrow: A=0, B=1, Sub=1.
  - Expected: S=all ones (0xFFFF…FFFF), Cout=0, Ovf=0.
- Signed overflow: A=0x7FFF…FFFF, B=1, Sub=0.
  - Expected: S=0x8000…0000, Cout=0, Ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Expected: S/Cout/Ovf and out_valid unchanged throughout; in_ready=0; a single result is consumed when out_ready=1; in_ready returns the next cycle.
- Reset mid-RUN: drop rst_n at k=2.
  - Expected: out_valid=0, S=0, in_ready=1 immediately.
  - A fresh op 5+7 after reset gives S=12.
- Random back-to-back: 1000 random A/B/Sub with random out_ready.
  - Expected: S/Cout/Ovf match the reference model for each op; exactly WORDS cycles from accept to out_valid.
